instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
Initiator side of the instruction-memory read interface: owns the program counter, drives the word address into instruction memory and captures the returned instruction into the IF/ID pipeline register. Handles stall, flush and branch/jump redirect from later stages. Sits between the instruction memory and the decode stage of the single-issue pipeline.

Parameters:
MEM_DEPTH, 1024, instruction memory depth in 32-bit words; PC is a word index (0..MEM_DEPTH-1)
RESET_PC, 0, word index loaded into PC on reset
HALT_WORD, 32'hFFFFFFFF, encoding treated as halt (used only with optional feature)

Ports:
Clk  input  1  system clock, rising-edge
Reset  input  1  asynchronous, active-low reset
Stall  input  1  hazard unit: hold PC and IF/ID
Flush  input  1  squash IF/ID contents (bubble)
BranchTaken  input  1  redirect PC this cycle
BranchTarget  input  32  redirect word index
instructionIn  input  32  instruction memory read data (combinational from programCounterOut)
programCounterOut  output  32  current PC, drives memory address
ifidInstruction  output  32  registered instruction to decode
ifidPcPlus1  output  32  registered PC+1 of that instruction
ifidValid  output  1  IF/ID holds a real instruction
addrError  output  1  sticky: redirect target >= MEM_DEPTH
fetchCount  output  32  number of instructions accepted into IF/ID

Behaviour:
- Reset (Reset low, async): PC=RESET_PC, ifidInstruction=0, ifidPcPlus1=0, ifidValid=0, addrError=0, fetchCount=0, state=BOOT.
- States: BOOT, RUN (HALTED only with optional feature).
- BOOT: exactly one cycle after reset release; PC holds, IF/ID stays invalid; -> RUN unconditionally (memory read data settles).
- RUN next-PC priority per rising edge: BranchTaken > Stall > sequential.
  - BranchTaken: PC <= BranchTarget mod MEM_DEPTH; if BranchTarget >= MEM_DEPTH set addrError (cleared only by reset). Redirect wins even when Stall=1.
  - Stall (no branch): PC holds.
  - Otherwise PC <= PC+1; PC=MEM_DEPTH-1 wraps to 0.
- IF/ID update, same edge, priority Flush|BranchTaken > Stall > capture:
  - Flush or BranchTaken: ifidInstruction=0 (nop), ifidValid=0, ifidPcPlus1=0.
  - Stall: all IF/ID outputs hold.
  - Capture: ifidInstruction=instructionIn, ifidPcPlus1=PC+1 (wrapped), ifidValid=1, fetchCount+1.
- Latency: instruction at PC=n appears on ifidInstruction one edge after PC=n is presented.
- fetchCount wraps 2^32-1 -> 0.
- programCounterOut is the PC register directly (no combinational path from inputs).
- Stall and Flush both high, no branch: flush wins, PC holds.
- Reset asserted mid-operation: immediate return to reset values regardless of state.

Optional Feature:
Macro IFU_HALT_DETECT_EN.
- Defined: on a capture where instructionIn == HALT_WORD, the word is captured (ifidValid=1), then state -> HALTED. HALTED: PC frozen, IF/ID loads nop with ifidValid=0 every cycle, fetchCount frozen; Stall/Flush/BranchTaken ignored; exit only via reset.
- Undefined: HALT_WORD is an ordinary instruction; no HALTED state; FSM is BOOT/RUN only.

Test Plan:
- Reset release, memory holds word k = 0x1000_0000+k -> cycle 1 ifidValid=0 (BOOT); then ifidInstruction 0x10000000, 0x10000001, ... with ifidPcPlus1 1, 2, ...; fetchCount increments each cycle.
- Stall high 3 cycles at PC=5 -> programCounterOut stays 5, IF/ID holds word 4, fetchCount unchanged; release -> word 5 captured next edge.
- BranchTaken=1, BranchTarget=200 with Stall=1 at PC=10 -> next PC=200, ifidValid=0; following edge ifidInstruction=word 200, ifidPcPlus1=201.
- BranchTarget=1030 -> PC=6, addrError=1 and stays 1 until Reset low.
- PC=1023 sequential -> next PC=0, captured ifidPcPlus1=0; Reset pulsed low mid-run -> outputs immediately zero/RESET_PC.
- With IFU_HALT_DETECT_EN, word 3 = 0xFFFFFFFF -> captured with ifidValid=1, then ifidValid=0, PC frozen at 4, BranchTaken ignored; without macro -> fetch continues to word 4.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Brief    : PC owner, instruction-memory address driver and IF/ID register.
//            Optional halt detection enabled by defining IFU_HALT_DETECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned RESET_PC  = 0,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] instructionIn,
  output logic [31:0] programCounterOut,
  output logic [31:0] ifidInstruction,
  output logic [31:0] ifidPcPlus1,
  output logic        ifidValid,
  output logic        addrError,
  output logic [31:0] fetchCount
);

  localparam logic [31:0] c_depth    = 32'(MEM_DEPTH);
  localparam logic [31:0] c_last     = c_depth - 32'd1;
  localparam logic [31:0] c_reset_pc = 32'(RESET_PC);
  localparam logic [31:0] c_nop      = 32'd0;

`ifdef IFU_HALT_DETECT_EN
  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1
  } state_t;

  // Without halt detection the halt encoding is an ordinary instruction.
  logic w_unused_halt;
  assign w_unused_halt = ^HALT_WORD;
`endif

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_pcp1, w_pcp1_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_err, w_err_nxt;
  logic [31:0] r_cnt, w_cnt_nxt;

  logic [31:0] w_pc_inc;
  logic [31:0] w_tgt_mod;
  logic        w_tgt_oor;

  assign w_pc_inc  = (r_pc == c_last) ? 32'd0 : r_pc + 32'd1;
  assign w_tgt_oor = (BranchTarget >= c_depth);
  assign w_tgt_mod = BranchTarget % c_depth;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_BOOT;
      r_pc    <= c_reset_pc;
      r_instr <= c_nop;
      r_pcp1  <= 32'd0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_pcp1  <= w_pcp1_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_pcp1_nxt  = r_pcp1;
    w_valid_nxt = r_valid;
    w_err_nxt   = r_err;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      // Memory read data is not trusted until one cycle after reset release.
      S_BOOT: w_state_nxt = S_RUN;
      S_RUN: begin
        if (BranchTaken) begin
          w_pc_nxt = w_tgt_mod;
          if (w_tgt_oor) w_err_nxt = 1'b1;
        end else if (!Stall) begin
          w_pc_nxt = w_pc_inc;
        end
        if (Flush || BranchTaken) begin
          w_instr_nxt = c_nop;
          w_pcp1_nxt  = 32'd0;
          w_valid_nxt = 1'b0;
        end else if (!Stall) begin
          w_instr_nxt = instructionIn;
          w_pcp1_nxt  = w_pc_inc;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = r_cnt + 32'd1;
`ifdef IFU_HALT_DETECT_EN
          if (instructionIn == HALT_WORD) w_state_nxt = S_HALTED;
`endif
        end
      end
`ifdef IFU_HALT_DETECT_EN
      // Halted: bubbles forever, all redirects and hazards ignored.
      S_HALTED: begin
        w_instr_nxt = c_nop;
        w_pcp1_nxt  = 32'd0;
        w_valid_nxt = 1'b0;
      end
`endif
      default: w_state_nxt = S_BOOT;
    endcase
  end

  assign programCounterOut = r_pc;
  assign ifidInstruction   = r_instr;
  assign ifidPcPlus1       = r_pcp1;
  assign ifidValid         = r_valid;
  assign addrError         = r_err;
  assign fetchCount        = r_cnt;

endmodule
`default_nettype wire
